// File: rtl/boxcar_sum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boxcar_sum_pkg
//  Description : Shared widths and trigger FSM encodings for boxcar_sum.
//  Revision    : 1.0 - initial release
// ============================================================================
package boxcar_sum_pkg;

    localparam int C_NBITS_DATA    = 42;
    localparam int C_NBITS_ADDR    = 9;
    localparam int C_NBITS_HOLDOFF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FIRED   = 2'd2,
        ST_HOLDOFF = 2'd3
    } trig_state_t;

endpackage
`default_nettype wire

// File: rtl/boxcar_trig_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : boxcar_trig_fsm
//  Description : Threshold trigger FSM with holdoff counter for boxcar_sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module boxcar_trig_fsm
    import boxcar_sum_pkg::*;
#(
    parameter int P_NBITS_SUM     = C_NBITS_DATA + C_NBITS_ADDR,
    parameter int P_NBITS_HOLDOFF = C_NBITS_HOLDOFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       upd,
    input  logic                       sum_valid,
    input  logic                       sum_valid_next,
    input  logic [P_NBITS_SUM-1:0]     sum_next,
    input  logic [P_NBITS_SUM-1:0]     thresh,
    input  logic [P_NBITS_HOLDOFF-1:0] holdoff,
    output logic                       trig,
    output logic [1:0]                 state
);

    trig_state_t                r_state;
    logic                       r_trig;
    logic [P_NBITS_HOLDOFF-1:0] r_hcnt;

    // Decisions use the next sum so trig and state land with the updated sum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_trig  <= 1'b0;
            r_hcnt  <= '0;
        end else begin
            r_trig <= 1'b0;
            if (clear || !sum_valid_next) begin
                r_state <= ST_IDLE;
                r_hcnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (sum_valid) r_state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (upd && (sum_next >= thresh)) begin
                            r_state <= ST_FIRED;
                            r_trig  <= 1'b1;
                        end
                    end
                    ST_FIRED: begin
                        if (upd && (sum_next < thresh)) begin
                            r_state <= ST_HOLDOFF;
                            r_hcnt  <= holdoff;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (r_hcnt == '0) begin
                            r_state <= ST_ARMED;
                        end else if (upd) begin
                            r_hcnt <= r_hcnt - 1'b1;
                            if (r_hcnt == P_NBITS_HOLDOFF'(1)) r_state <= ST_ARMED;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign trig  = r_trig;
    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/boxcar_sum.sv
`default_nettype none
// ============================================================================
//  Module      : boxcar_sum
//  Description : Running boxcar sum over n samples with threshold trigger.
//  Revision    : 1.0 - initial release
// ============================================================================
module boxcar_sum
    import boxcar_sum_pkg::*;
#(
    parameter int P_NBITS_DATA = C_NBITS_DATA,
    parameter int P_NBITS_ADDR = C_NBITS_ADDR,
    parameter int P_NBITS_SUM  = P_NBITS_DATA + P_NBITS_ADDR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_wr,
    input  logic [P_NBITS_DATA-1:0]    qn,
    input  logic [P_NBITS_DATA-1:0]    qo,
    input  logic [P_NBITS_ADDR-1:0]    n,
    input  logic [P_NBITS_SUM-1:0]     thresh,
    input  logic [C_NBITS_HOLDOFF-1:0] holdoff,
    output logic [P_NBITS_SUM-1:0]     sum,
    output logic                       sum_valid,
    output logic                       trig,
    output logic [1:0]                 state
);

    logic [P_NBITS_ADDR-1:0] r_n;
    logic [P_NBITS_ADDR-1:0] r_fill;
    logic [P_NBITS_SUM-1:0]  r_sum;
    logic                    r_valid;

    logic                    w_n_change;
    logic                    w_upd;
    logic [P_NBITS_ADDR-1:0] w_fill_inc;
    logic [P_NBITS_ADDR-1:0] w_fill_next;
    logic [P_NBITS_SUM-1:0]  w_sum_next;
    logic                    w_valid_next;
    logic [P_NBITS_SUM-1:0]  w_qn_ext;
    logic [P_NBITS_SUM-1:0]  w_qo_ext;

    assign w_n_change = (n != r_n);
    assign w_upd      = in_wr && !w_n_change && (r_n != '0);
    assign w_fill_inc = r_fill + 1'b1;
    assign w_qn_ext   = P_NBITS_SUM'(qn);
    assign w_qo_ext   = P_NBITS_SUM'(qo);

    always_comb begin
        w_sum_next   = r_sum;
        w_fill_next  = r_fill;
        w_valid_next = r_valid;
        if (w_n_change) begin
            w_sum_next   = '0;
            w_fill_next  = '0;
            w_valid_next = 1'b0;
        end else if (w_upd) begin
            if (r_fill != r_n) begin
                w_sum_next   = r_sum + w_qn_ext;
                w_fill_next  = w_fill_inc;
                w_valid_next = (w_fill_inc == r_n);
            end else begin
                w_sum_next   = r_sum + w_qn_ext - w_qo_ext;
            end
        end
    end

    // n is tracked every cycle; a mismatch against r_n is the restart request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_n     <= n;
            r_fill  <= '0;
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_n     <= n;
            r_fill  <= w_fill_next;
            r_sum   <= w_sum_next;
            r_valid <= w_valid_next;
        end
    end

    boxcar_trig_fsm #(
        .P_NBITS_SUM     (P_NBITS_SUM),
        .P_NBITS_HOLDOFF (C_NBITS_HOLDOFF)
    ) u_trig_fsm (
        .clk            (clk),
        .rst            (rst),
        .clear          (w_n_change),
        .upd            (w_upd),
        .sum_valid      (r_valid),
        .sum_valid_next (w_valid_next),
        .sum_next       (w_sum_next),
        .thresh         (thresh),
        .holdoff        (holdoff),
        .trig           (trig),
        .state          (state)
    );

    assign sum       = r_sum;
    assign sum_valid = r_valid;

endmodule
`default_nettype wire
